// File: rtl/instrmem_loader.sv
// rtl/instrmem_loader.sv - byte-stream loader/dumper for the instruction memory debug port (option: LOADER_BYTE_WRITE_EN)
module instrmem_loader #(
    parameter int NB_INSTR = 32,
    parameter int NB_ADDR  = 16,
    parameter int N_WORDS  = 2048
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic [7:0]          i_rx_data,
    input  logic                i_rx_valid,
    output logic                o_rx_ready,
    output logic [7:0]          o_tx_data,
    output logic                o_tx_valid,
    input  logic                i_tx_ready,
    input  logic                i_start_load,
    input  logic                i_start_dump,
    output logic [NB_ADDR-1:0]  o_instrmem_addr,
    output logic [NB_INSTR-1:0] o_instrmem_data,
    output logic [3:0]          o_instrmem_we,
    output logic                o_instrmem_re,
    input  logic [NB_INSTR-1:0] i_instrmem_data,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_error,
    output logic [NB_ADDR-1:0]  o_word_count
);

    typedef enum logic [3:0] {
        IDLE, LEN0, LEN1, RX_WORD, WRITE, RD_REQ, RD_WAIT, TX_BYTE, DONE
    } state_t;

    localparam logic [16:0] MAX_WORDS = 17'(N_WORDS);

    state_t              state;
    state_t              state_next;
    logic [NB_ADDR-1:0]  addr;
    logic [NB_ADDR-1:0]  word_count;
    logic [1:0]          byte_cnt;
    logic [NB_INSTR-1:0] word_buf;
    logic [7:0]          len_lo;
    logic                error;
    logic [15:0]         len_full;
    logic                rx_fire;
    logic                tx_fire;
    logic                last_word;
    logic                len_too_big;
`ifdef LOADER_BYTE_WRITE_EN
    logic                byte_pending;
    logic [1:0]          byte_lane;
`endif

    assign len_full     = {i_rx_data, len_lo};
    assign len_too_big  = {1'b0, len_full} > MAX_WORDS;
    assign rx_fire      = i_rx_valid & o_rx_ready;
    assign tx_fire      = o_tx_valid & i_tx_ready;
    assign last_word    = (addr == word_count - 1'b1);
    assign o_busy       = (state != IDLE);
    assign o_done       = (state == DONE);
    assign o_error      = error;
    assign o_word_count = word_count;
    assign o_instrmem_addr = addr;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next      = state;
        o_rx_ready      = 1'b0;
        o_instrmem_we   = 4'b0000;
        o_instrmem_re   = 1'b0;
        o_instrmem_data = '0;
        o_tx_data       = 8'h00;
        o_tx_valid      = 1'b0;
        case (state)
            IDLE: begin
                if (i_start_load) begin
                    state_next = LEN0;
                end else if (i_start_dump) begin
                    state_next = (word_count == '0) ? DONE : RD_REQ;
                end
            end
            LEN0: begin
                o_rx_ready = 1'b1;
                if (i_rx_valid) begin
                    state_next = LEN1;
                end
            end
            LEN1: begin
                o_rx_ready = 1'b1;
                if (i_rx_valid) begin
                    if (len_full == 16'h0000) begin
                        state_next = DONE;
                    end else if (len_too_big) begin
                        state_next = IDLE;
                    end else begin
                        state_next = RX_WORD;
                    end
                end
            end
            RX_WORD: begin
`ifdef LOADER_BYTE_WRITE_EN
                // The byte just accepted sits in the top lane of word_buf after the shift.
                o_rx_ready = !byte_pending;
                if (byte_pending) begin
                    o_instrmem_we   = 4'b0001 << byte_lane;
                    o_instrmem_data = {(NB_INSTR/8){word_buf[NB_INSTR-1 -: 8]}};
                    if (byte_lane == 2'd3) begin
                        state_next = last_word ? DONE : RX_WORD;
                    end
                end
`else
                o_rx_ready = 1'b1;
                if (i_rx_valid && byte_cnt == 2'd3) begin
                    state_next = WRITE;
                end
`endif
            end
            WRITE: begin
                o_instrmem_we   = 4'b1111;
                o_instrmem_data = word_buf;
                state_next      = last_word ? DONE : RX_WORD;
            end
            RD_REQ: begin
                o_instrmem_re = 1'b1;
                state_next    = RD_WAIT;
            end
            RD_WAIT: begin
                state_next = TX_BYTE;
            end
            TX_BYTE: begin
                o_tx_valid = 1'b1;
                o_tx_data  = word_buf[7:0];
                if (i_tx_ready && byte_cnt == 2'd3) begin
                    state_next = last_word ? DONE : RD_REQ;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            addr         <= '0;
            word_count   <= '0;
            byte_cnt     <= 2'd0;
            word_buf     <= '0;
            len_lo       <= 8'h00;
            error        <= 1'b0;
`ifdef LOADER_BYTE_WRITE_EN
            byte_pending <= 1'b0;
            byte_lane    <= 2'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (i_start_load) begin
                        addr     <= '0;
                        byte_cnt <= 2'd0;
                        error    <= 1'b0;
                    end else if (i_start_dump) begin
                        addr     <= '0;
                        byte_cnt <= 2'd0;
                    end
                end
                LEN0: begin
                    if (rx_fire) begin
                        len_lo <= i_rx_data;
                    end
                end
                LEN1: begin
                    if (rx_fire) begin
                        if (len_too_big) begin
                            error <= 1'b1;
                        end else begin
                            word_count <= NB_ADDR'(len_full);
                        end
                    end
                end
                RX_WORD: begin
                    // Bytes arrive LSB-first, so shifting in from the top leaves them in place.
                    if (rx_fire) begin
                        word_buf <= {i_rx_data, word_buf[NB_INSTR-1:8]};
                        byte_cnt <= byte_cnt + 2'd1;
`ifdef LOADER_BYTE_WRITE_EN
                        byte_pending <= 1'b1;
                        byte_lane    <= byte_cnt;
`endif
                    end
`ifdef LOADER_BYTE_WRITE_EN
                    if (byte_pending) begin
                        byte_pending <= 1'b0;
                        if (byte_lane == 2'd3 && !last_word) begin
                            addr <= addr + 1'b1;
                        end
                    end
`endif
                end
                WRITE: begin
                    if (!last_word) begin
                        addr <= addr + 1'b1;
                    end
                end
                RD_WAIT: begin
                    word_buf <= i_instrmem_data;
                end
                TX_BYTE: begin
                    if (tx_fire) begin
                        word_buf <= {8'h00, word_buf[NB_INSTR-1:8]};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3 && !last_word) begin
                            addr <= addr + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instrmem_loader.sv
// tb/tb_instrmem_loader.sv - directed self-checking bench for instrmem_loader
module tb_instrmem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        o_rx_ready;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        tx_ready = 1'b0;
    logic        start_load = 1'b0;
    logic        start_dump = 1'b0;
    logic [15:0] o_instrmem_addr;
    logic [31:0] o_instrmem_data;
    logic [3:0]  o_instrmem_we;
    logic        o_instrmem_re;
    logic [31:0] rdata = 32'h0;
    logic        o_busy;
    logic        o_done;
    logic        o_error;
    logic [15:0] o_word_count;

    logic [31:0] mem [0:15];
    logic [15:0] log_addr [0:31];
    logic [31:0] log_data [0:31];
    logic [3:0]  log_we   [0:31];
    int n_wr = 0;
    int n_done = 0;
    int n_re = 0;
    int errors = 0;
    int checks = 0;

`ifdef LOADER_BYTE_WRITE_EN
    localparam int WPW = 4;
`else
    localparam int WPW = 1;
`endif

    instrmem_loader dut (
        .i_clock         (clk),
        .i_reset         (rst_n),
        .i_rx_data       (rx_data),
        .i_rx_valid      (rx_valid),
        .o_rx_ready      (o_rx_ready),
        .o_tx_data       (o_tx_data),
        .o_tx_valid      (o_tx_valid),
        .i_tx_ready      (tx_ready),
        .i_start_load    (start_load),
        .i_start_dump    (start_dump),
        .o_instrmem_addr (o_instrmem_addr),
        .o_instrmem_data (o_instrmem_data),
        .o_instrmem_we   (o_instrmem_we),
        .o_instrmem_re   (o_instrmem_re),
        .i_instrmem_data (rdata),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_error         (o_error),
        .o_word_count    (o_word_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_done) n_done++;
        if (o_instrmem_re) n_re++;
        if (o_instrmem_we != 4'b0000) begin
            if (n_wr < 32) begin
                log_addr[n_wr] = o_instrmem_addr;
                log_data[n_wr] = o_instrmem_data;
                log_we[n_wr]   = o_instrmem_we;
            end
            n_wr++;
            for (int i = 0; i < 4; i++)
                if (o_instrmem_we[i]) mem[o_instrmem_addr[3:0]][8*i +: 8] = o_instrmem_data[8*i +: 8];
        end
    end

    always @(posedge clk) if (o_instrmem_re) rdata <= mem[o_instrmem_addr[3:0]];

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        rx_data = b;
        rx_valid = 1'b1;
        while (o_rx_ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        checks++;
        if (t >= 50) begin errors++; $display("FAIL send_byte: rx_ready=%0b after %0d cycles, required 1", o_rx_ready, t); end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (o_busy === 1'b1 && t < 200) begin @(negedge clk); t++; end
        checks++;
        if (t >= 200) begin errors++; $display("FAIL wait_idle: busy=%0b after %0d cycles, required 0", o_busy, t); end
    endtask

    task automatic pulse_load();
        start_load = 1'b1;
        @(negedge clk);
        start_load = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({o_busy, o_done, o_error, o_rx_ready, o_tx_valid, o_instrmem_re, o_instrmem_we} !== 10'b0)
            begin errors++; $display("FAIL reset_flags: got %b required 0", {o_busy, o_done, o_error, o_rx_ready, o_tx_valid, o_instrmem_re, o_instrmem_we}); end
        checks++;
        if (o_word_count !== 16'h0 || o_instrmem_addr !== 16'h0 || o_instrmem_data !== 32'h0 || o_tx_data !== 8'h0)
            begin errors++; $display("FAIL reset_data: wc=%h addr=%h data=%h tx=%h required all 0", o_word_count, o_instrmem_addr, o_instrmem_data, o_tx_data); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_release_idle: busy=%0b required 0", o_busy); end
    endtask

    task automatic test_load();
        int wr0, dn0;
        wr0 = n_wr;
        dn0 = n_done;
        pulse_load();
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
        wait_idle();
        checks++;
        if (mem[0] !== 32'h12345678 || mem[1] !== 32'hDEADBEEF)
            begin errors++; $display("FAIL load_mem: mem0=%h mem1=%h required 12345678 deadbeef", mem[0], mem[1]); end
        checks++;
        if (n_wr - wr0 !== 2 * WPW) begin errors++; $display("FAIL load_write_count: got %0d required %0d", n_wr - wr0, 2 * WPW); end
`ifndef LOADER_BYTE_WRITE_EN
        checks++;
        if (log_addr[wr0] !== 16'd0 || log_data[wr0] !== 32'h12345678 || log_we[wr0] !== 4'b1111)
            begin errors++; $display("FAIL load_write0: addr=%h data=%h we=%b required 0 12345678 1111", log_addr[wr0], log_data[wr0], log_we[wr0]); end
        checks++;
        if (log_addr[wr0+1] !== 16'd1 || log_data[wr0+1] !== 32'hDEADBEEF || log_we[wr0+1] !== 4'b1111)
            begin errors++; $display("FAIL load_write1: addr=%h data=%h we=%b required 1 deadbeef 1111", log_addr[wr0+1], log_data[wr0+1], log_we[wr0+1]); end
`endif
        checks++;
        if (o_word_count !== 16'd2) begin errors++; $display("FAIL load_word_count: got %0d required 2", o_word_count); end
        checks++;
        if (n_done - dn0 !== 1) begin errors++; $display("FAIL load_done_pulses: got %0d required 1", n_done - dn0); end
    endtask

    task automatic test_dump();
        logic [7:0] exp_bytes [0:7];
        logic [7:0] got;
        int t, re0, dn0;
        exp_bytes = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        re0 = n_re;
        dn0 = n_done;
        start_dump = 1'b1;
        @(negedge clk);
        start_dump = 1'b0;
        for (int i = 0; i < 8; i++) begin
            t = 0;
            while (o_tx_valid !== 1'b1 && t < 50) begin @(negedge clk); t++; end
            checks++;
            if (t >= 50) begin errors++; $display("FAIL dump_valid_timeout: byte %0d tx_valid=%0b required 1", i, o_tx_valid); end
            got = o_tx_data;
            if (i == 2) begin
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    checks++;
                    if (o_tx_valid !== 1'b1 || o_tx_data !== got)
                        begin errors++; $display("FAIL dump_stall_stable: cycle %0d valid=%0b data=%h required 1 %h", s, o_tx_valid, o_tx_data, got); end
                end
            end
            checks++;
            if (got !== exp_bytes[i]) begin errors++; $display("FAIL dump_byte: index %0d got %h required %h", i, got, exp_bytes[i]); end
            tx_ready = 1'b1;
            @(negedge clk);
            tx_ready = 1'b0;
        end
        wait_idle();
        checks++;
        if (n_re - re0 !== 2) begin errors++; $display("FAIL dump_reads: got %0d required 2", n_re - re0); end
        checks++;
        if (n_done - dn0 !== 1) begin errors++; $display("FAIL dump_done_pulses: got %0d required 1", n_done - dn0); end
    endtask

    task automatic test_overflow();
        int wr0, dn0;
        wr0 = n_wr;
        dn0 = n_done;
        pulse_load();
        send_byte(8'h01); send_byte(8'h08);
        repeat (2) @(negedge clk);
        checks++;
        if (o_error !== 1'b1) begin errors++; $display("FAIL overflow_error: got %0b required 1", o_error); end
        checks++;
        if (o_busy !== 1'b0) begin errors++; $display("FAIL overflow_idle: busy=%0b required 0", o_busy); end
        checks++;
        if (n_wr !== wr0 || n_done !== dn0)
            begin errors++; $display("FAIL overflow_side_effects: writes=%0d done=%0d required 0 0", n_wr - wr0, n_done - dn0); end
        checks++;
        if (o_word_count !== 16'd2) begin errors++; $display("FAIL overflow_word_count: got %0d required 2", o_word_count); end
    endtask

    task automatic test_start_collision();
        int wr0, dn0, re0;
        wr0 = n_wr;
        dn0 = n_done;
        re0 = n_re;
        start_load = 1'b1;
        start_dump = 1'b1;
        @(negedge clk);
        start_load = 1'b0;
        start_dump = 1'b0;
        checks++;
        if (o_rx_ready !== 1'b1 || o_error !== 1'b0)
            begin errors++; $display("FAIL collision_load_wins: rx_ready=%0b error=%0b required 1 0", o_rx_ready, o_error); end
        send_byte(8'h01); send_byte(8'h00);
        start_dump = 1'b1;
        @(negedge clk);
        start_dump = 1'b0;
        send_byte(8'h0D); send_byte(8'hF0); send_byte(8'hFE); send_byte(8'hCA);
        wait_idle();
        checks++;
        if (mem[0] !== 32'hCAFEF00D) begin errors++; $display("FAIL collision_mem: got %h required cafef00d", mem[0]); end
        checks++;
        if (n_wr - wr0 !== WPW || n_re !== re0)
            begin errors++; $display("FAIL collision_ops: writes=%0d reads=%0d required %0d 0", n_wr - wr0, n_re - re0, WPW); end
        checks++;
        if (n_done - dn0 !== 1 || o_word_count !== 16'd1)
            begin errors++; $display("FAIL collision_done: done=%0d wc=%0d required 1 1", n_done - dn0, o_word_count); end
    endtask

`ifdef LOADER_BYTE_WRITE_EN
    task automatic test_byte_write();
        logic [7:0] bytes [0:3];
        int wr0;
        bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        wr0 = n_wr;
        pulse_load();
        send_byte(8'h01); send_byte(8'h00);
        for (int i = 0; i < 4; i++) send_byte(bytes[i]);
        wait_idle();
        checks++;
        if (n_wr - wr0 !== 4) begin errors++; $display("FAIL byte_write_count: got %0d required 4", n_wr - wr0); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (log_addr[wr0+i] !== 16'd0 || log_we[wr0+i] !== 4'(1 << i) || log_data[wr0+i] !== {4{bytes[i]}})
                begin errors++; $display("FAIL byte_write: index %0d addr=%h we=%b data=%h required 0 %b %h", i, log_addr[wr0+i], log_we[wr0+i], log_data[wr0+i], 4'(1 << i), {4{bytes[i]}}); end
        end
    endtask
`endif

    task automatic test_reset_mid_load();
        pulse_load();
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h55); send_byte(8'h66);
        checks++;
        if (o_word_count !== 16'd2 || o_busy !== 1'b1)
            begin errors++; $display("FAIL midload_state: wc=%0d busy=%0b required 2 1", o_word_count, o_busy); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({o_busy, o_done, o_error, o_rx_ready, o_tx_valid, o_instrmem_re, o_instrmem_we} !== 10'b0)
            begin errors++; $display("FAIL midload_reset_flags: got %b required 0", {o_busy, o_done, o_error, o_rx_ready, o_tx_valid, o_instrmem_re, o_instrmem_we}); end
        checks++;
        if (o_word_count !== 16'h0 || o_instrmem_addr !== 16'h0 || o_instrmem_data !== 32'h0)
            begin errors++; $display("FAIL midload_reset_data: wc=%h addr=%h data=%h required 0", o_word_count, o_instrmem_addr, o_instrmem_data); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b0) begin errors++; $display("FAIL midload_no_resume: busy=%0b required 0", o_busy); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_dump();
        test_overflow();
        test_start_collision();
`ifdef LOADER_BYTE_WRITE_EN
        test_byte_write();
`endif
        test_reset_mid_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instrmem_loader.md
INSTRMEM_LOADER -- requirements
Module: instrmem_loader

Interface
REQ-001 SHALL have parameter NB_INSTR, default 32, instruction word width.
REQ-002 SHALL have parameter NB_ADDR, default 16, memory debug-port address width.
REQ-003 SHALL have parameter N_WORDS, default 2048, maximum loadable words.
REQ-004 SHALL have ports, one per line, in this order:
- i_clock, in, 1: single clock; all state on rising edge.
- i_reset, in, 1: asynchronous, active-low reset.
- i_rx_data, in, 8: incoming byte.
- i_rx_valid, in, 1: i_rx_data valid.
- o_rx_ready, out, 1: byte accepted when valid&ready.
- o_tx_data, out, 8: outgoing readback byte.
- o_tx_valid, out, 1: o_tx_data valid.
- i_tx_ready, in, 1: byte consumed when valid&ready.
- i_start_load, in, 1: one-cycle pulse, begin load.
- i_start_dump, in, 1: one-cycle pulse, begin readback.
- o_instrmem_addr, out, NB_ADDR: word address to memory debug port.
- o_instrmem_data, out, NB_INSTR: write data.
- o_instrmem_we, out, 4: byte-lane write enables.
- o_instrmem_re, out, 1: read enable.
- i_instrmem_data, in, NB_INSTR: read data, valid one cycle after o_instrmem_re.
- o_busy, out, 1: not IDLE.
- o_done, out, 1: one-cycle pulse on operation completion.
- o_error, out, 1: sticky; word count exceeded N_WORDS.
- o_word_count, out, NB_ADDR: word count of last accepted load.

Function
REQ-005 SHALL implement states IDLE, LEN0, LEN1, RX_WORD, WRITE, RD_REQ, RD_WAIT, TX_BYTE, DONE.
REQ-006 IDLE: i_start_load -> LEN0, clears o_error; i_start_dump -> RD_REQ; both asserted together -> load wins; starts outside IDLE SHALL be ignored.
REQ-007 LEN0/LEN1 SHALL accept two bytes, little-endian, forming word count N.
REQ-008 N=0 SHALL go to DONE with no writes; N>N_WORDS SHALL set o_error and go to IDLE with no writes and no o_done; otherwise o_word_count<=N and go to RX_WORD.
REQ-009 RX_WORD SHALL assemble four accepted bytes LSB-first into a word, then enter WRITE.
REQ-010 WRITE SHALL last exactly one cycle: o_instrmem_we=4'b1111, o_instrmem_addr=word index k (0..N-1), o_instrmem_data=assembled word; o_rx_ready=0 in this cycle.
REQ-011 After write of word N-1 SHALL enter DONE; else k+1 and RX_WORD.
REQ-012 o_rx_ready SHALL be 1 only in LEN0, LEN1, RX_WORD.
REQ-013 Dump: RD_REQ asserts o_instrmem_re for one cycle at address k; RD_WAIT captures i_instrmem_data the following cycle; TX_BYTE emits four bytes LSB-first, holding o_tx_data/o_tx_valid stable until i_tx_ready.
REQ-014 Dump SHALL cover k=0..o_word_count-1; o_word_count=0 -> DONE immediately.
REQ-015 DONE SHALL pulse o_done for one cycle, then IDLE.
REQ-016 Outside WRITE o_instrmem_we SHALL be 0; outside RD_REQ o_instrmem_re SHALL be 0.
REQ-017 Address counter SHALL be NB_ADDR wide, zeroed at each start, never wrapping (bounded by REQ-008).

Reset
REQ-018 i_reset low SHALL asynchronously force IDLE and zero all outputs, counters and word buffer, including o_error and o_word_count.
REQ-019 Reset mid-WRITE SHALL deassert o_instrmem_we immediately; a partial load is not resumed.

Configuration
REQ-020 With macro LOADER_BYTE_WRITE_EN defined, each accepted byte in RX_WORD SHALL be written immediately the following cycle with o_instrmem_we=1<<byte_index and the byte replicated across o_instrmem_data lanes; WRITE state is then unused and o_rx_ready drops for that cycle.
REQ-021 Without LOADER_BYTE_WRITE_EN, only full-word writes per REQ-010 SHALL occur.

Verification
REQ-022 Load: bytes 02 00, 78 56 34 12, EF BE AD DE -> writes addr0=0x12345678, addr1=0xDEADBEEF, we=1111, o_word_count=2, one o_done pulse.
REQ-023 Dump after REQ-022 with memory model latency 1 -> tx bytes 78 56 34 12 EF BE AD DE; i_tx_ready held low 5 cycles mid-word -> data stable, no loss.
REQ-024 Load count 0x0801 (N_WORDS=2048) -> o_error=1, no writes, no o_done, IDLE.
REQ-025 i_start_load and i_start_dump same cycle -> load performed; i_start_dump while busy -> ignored.
REQ-026 Reset asserted during RX_WORD of word 1 -> all outputs 0 immediately, IDLE, o_word_count=0.
REQ-027 LOADER_BYTE_WRITE_EN defined, load N=1 bytes AA BB CC DD -> four writes addr0 we=0001,0010,0100,1000 with data AAAAAAAA..DDDDDDDD.
